// File: rtl/mips_encode.sv
// mips_encode: assembles ALU-op requests into 32-bit MIPS R-type / I-type
// instruction words and buffers them in a small FIFO for a downstream
// valid/ready consumer. Illegal op/format combinations are accepted, dropped,
// flagged with a one-cycle except pulse and counted.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   request handshake; in_ready = FIFO not full (registered)
//   in_op, in_imm    ALU op and form select (0 = R-type, 1 = I-type)
//   in_rs/rt/rd      register fields; in_rd ignored for I-type
//   in_imm16         immediate; ignored for R-type
//   out_valid/ready  FIFO head handshake
//   out_instr        head word, 0 while out_valid = 0
//   except           pulse the cycle after an illegal request is accepted
//   err_count        illegal accepts, saturating at 255
//   emit_count       delivered words, wraps modulo 2^16
module mips_encode #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_imm,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        except,
    output logic [7:0]  err_count,
    output logic [15:0] emit_count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned EMIT_W  = 16;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic               except_q, except_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [EMIT_W-1:0]  emit_count_q, emit_count_d;

    logic [INSTR_W-1:0] word_c;
    logic               illegal_c;
    logic               accept_c;
    logic               push_c;
    logic               pop_c;

    // Instruction assembly and legality check
    always_comb begin
        logic [5:0] funct;
        logic [5:0] opcode;
        logic       imm_ok;
        funct     = 6'h00;
        opcode    = 6'h00;
        imm_ok    = 1'b0;
        illegal_c = 1'b0;
        word_c    = '0;
        case (in_op)
            3'b010:  begin funct = 6'h20; opcode = 6'h08; imm_ok = 1'b1; end
            3'b011:  begin funct = 6'h22; end
            3'b100:  begin funct = 6'h24; opcode = 6'h0C; imm_ok = 1'b1; end
            3'b101:  begin funct = 6'h25; opcode = 6'h0D; imm_ok = 1'b1; end
            3'b110:  begin funct = 6'h27; end
            3'b111:  begin funct = 6'h26; opcode = 6'h0E; imm_ok = 1'b1; end
            default: illegal_c = 1'b1;
        endcase
        if (in_imm && !imm_ok) begin
            illegal_c = 1'b1;
        end
        if (in_imm) begin
            word_c = {opcode, in_rs, in_rt, in_imm16};
        end else begin
            word_c = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct};
        end
    end

    assign accept_c = in_valid & in_ready_q;
    assign push_c   = accept_c & ~illegal_c;
    assign pop_c    = out_valid_q & out_ready;

    // FIFO bookkeeping, registered output view and counters
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        except_d     = accept_c & illegal_c;
        err_count_d  = err_count_q;
        emit_count_d = emit_count_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = word_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            emit_count_d = emit_count_q + EMIT_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept_c && illegal_c && err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        in_ready_d  = (count_d != FULL_CNT);
        out_valid_d = (count_d != '0);
        // The next head is the word being written when it lands in the head slot
        if (count_d == '0) begin
            out_instr_d = '0;
        end else if (push_c && wr_ptr_q == rd_ptr_d) begin
            out_instr_d = word_c;
        end else begin
            out_instr_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            except_q     <= 1'b0;
            err_count_q  <= '0;
            emit_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            except_q     <= except_d;
            err_count_q  <= err_count_d;
            emit_count_q <= emit_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign except     = except_q;
    assign err_count  = err_count_q;
    assign emit_count = emit_count_q;

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: hand-computed instruction words, FIFO
// ordering/backpressure, illegal-request flagging and asynchronous reset.
module tb_mips_encode;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_imm;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm16;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        except;
    logic [7:0]  err_count;
    logic [15:0] emit_count;

    int vectors;
    int miscompares;

    mips_encode #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_imm     (in_imm),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm16   (in_imm16),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .except     (except),
        .err_count  (err_count),
        .emit_count (emit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] i16);
        in_valid = 1'b1;
        in_op    = op;
        in_imm   = imm;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm16 = i16;
    endtask

    function automatic logic [31:0] add_word(input logic [4:0] r);
        return {6'd0, r, r, r, 5'd0, 6'h20};
    endfunction

    initial begin
        logic [2:0]  s_op  [6];
        logic        s_imm [6];
        logic [4:0]  s_rs  [6];
        logic [4:0]  s_rt  [6];
        logic [4:0]  s_rd  [6];
        logic [15:0] s_i16 [6];
        logic [31:0] s_exp [6];

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 3'b000;
        in_imm      = 1'b0;
        in_rs       = '0;
        in_rt       = '0;
        in_rd       = '0;
        in_imm16    = '0;
        out_ready   = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_except", 32'(except), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_emit_count", 32'(emit_count), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // add $3,$1,$2
        out_ready = 1'b1;
        req(3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_instr", out_instr, 32'h00221820);
        step();
        chk("add_emit", 32'(emit_count), 32'd1);
        chk("add_drained", 32'(out_valid), 32'd0);
        chk("add_instr_zero", out_instr, 32'd0);

        // addi then xori, held under backpressure, then drained in order
        out_ready = 1'b0;
        req(3'b010, 1'b1, 5'd4, 5'd5, 5'd0, 16'hFFFF);
        step();
        chk("addi_head", out_instr, 32'h2085FFFF);
        req(3'b111, 1'b1, 5'd6, 5'd7, 5'd0, 16'h00F0);
        step();
        in_valid = 1'b0;
        chk("addi_hold", out_instr, 32'h2085FFFF);
        out_ready = 1'b1;
        step();
        chk("xori_head", out_instr, 32'h38C700F0);
        step();
        chk("pair_drained", 32'(out_valid), 32'd0);
        chk("pair_emit", 32'(emit_count), 32'd3);

        // nor R-type, then the illegal nor-immediate form
        req(3'b110, 1'b0, 5'd8, 5'd10, 5'd9, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("nor_instr", out_instr, 32'h010A4827);
        step();
        chk("nor_emit", 32'(emit_count), 32'd4);
        req(3'b110, 1'b1, 5'd8, 5'd10, 5'd9, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("nori_except", 32'(except), 32'd1);
        chk("nori_err", 32'(err_count), 32'd1);
        chk("nori_no_out", 32'(out_valid), 32'd0);
        step();
        chk("nori_pulse_end", 32'(except), 32'd0);
        chk("nori_still_empty", 32'(out_valid), 32'd0);

        // Fill to full with backpressure, fifth request held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(3'b010, 1'b0, 5'(i + 1), 5'(i + 1), 5'(i + 1), 16'h0000);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        req(3'b010, 1'b0, 5'd5, 5'd5, 5'd5, 16'h0000);
        step();
        chk("full_held", 32'(in_ready), 32'd0);
        chk("full_head", out_instr, add_word(5'd1));
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fill_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("fill_word_%0d", k), out_instr, add_word(5'(k + 1)));
            step();
            if (k == 1) in_valid = 1'b0;
        end
        chk("fill_drained", 32'(out_valid), 32'd0);
        chk("fill_emit", 32'(emit_count), 32'd9);

        // Streaming push/pop of the remaining functions and immediate forms
        s_op[0] = 3'b011; s_imm[0] = 1'b0; s_rs[0] = 5'd2;  s_rt[0] = 5'd3;  s_rd[0] = 5'd1;  s_i16[0] = 16'hFFFF; s_exp[0] = 32'h00430822;
        s_op[1] = 3'b100; s_imm[1] = 1'b0; s_rs[1] = 5'd5;  s_rt[1] = 5'd6;  s_rd[1] = 5'd4;  s_i16[1] = 16'hFFFF; s_exp[1] = 32'h00A62024;
        s_op[2] = 3'b101; s_imm[2] = 1'b0; s_rs[2] = 5'd31; s_rt[2] = 5'd31; s_rd[2] = 5'd31; s_i16[2] = 16'h0000; s_exp[2] = 32'h03FFF825;
        s_op[3] = 3'b111; s_imm[3] = 1'b0; s_rs[3] = 5'd0;  s_rt[3] = 5'd0;  s_rd[3] = 5'd0;  s_i16[3] = 16'hABCD; s_exp[3] = 32'h00000026;
        s_op[4] = 3'b100; s_imm[4] = 1'b1; s_rs[4] = 5'd1;  s_rt[4] = 5'd2;  s_rd[4] = 5'd31; s_i16[4] = 16'h1234; s_exp[4] = 32'h30221234;
        s_op[5] = 3'b101; s_imm[5] = 1'b1; s_rs[5] = 5'd31; s_rt[5] = 5'd31; s_rd[5] = 5'd0;  s_i16[5] = 16'h8000; s_exp[5] = 32'h37FF8000;
        for (int i = 0; i < 6; i++) begin
            req(s_op[i], s_imm[i], s_rs[i], s_rt[i], s_rd[i], s_i16[i]);
            step();
            chk($sformatf("stream_%0d", i), out_instr, s_exp[i]);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_emit", 32'(emit_count), 32'd15);

        // 256 back-to-back illegal requests: saturating error count
        for (int k = 0; k < 256; k++) begin
            req((k % 2 == 0) ? 3'b000 : 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000);
            step();
            if (k % 32 == 0 || k == 255) begin
                chk($sformatf("ill_except_%0d", k), 32'(except), 32'd1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("ill_except_end", 32'(except), 32'd0);
        chk("ill_err_sat", 32'(err_count), 32'd255);
        chk("ill_no_out", 32'(out_valid), 32'd0);
        chk("ill_emit", 32'(emit_count), 32'd15);

        // Reset mid-operation with three words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(3'b010, 1'b0, 5'(i + 10), 5'(i + 10), 5'(i + 10), 16'h0000);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_emit", 32'(emit_count), 32'd0);
        #2;
        reset = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        req(3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("post_rst_word", out_instr, 32'h00221820);
        step();
        chk("post_rst_emit", 32'(emit_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
